// File: rtl/analyser_frame_controller.sv
// Frame-aligned audio analysis: windows codec samples on the game frame tick and
// reports a registered pitch class and volume flag over a valid/ack handshake.
module analyser_frame_controller #(
    parameter int unsigned          SAMPLE_W         = 24,
    parameter logic [SAMPLE_W-1:0]  VOL_THRESH       = 24'h3FFFFF,
    parameter int unsigned          PITCH_MID_XINGS  = 5,
    parameter int unsigned          PITCH_HIGH_XINGS = 10,
    parameter int unsigned          MIN_SAMPLES      = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                read_ready,
    input  logic [SAMPLE_W-1:0] left,
    input  logic                frame_tick,
    output logic                read_ack,
    input  logic                result_ack,
    output logic [1:0]          pitch,
    output logic                volumn,
    output logic                result_valid,
    output logic [11:0]         frame_samples,
    output logic                overrun,
    output logic [1:0]          dbg_state_o
);
    // Handshake: result_valid holds pitch/volumn/frame_samples stable until a cycle
    // with result_ack=1; a frame close in that same cycle loads the next result instead.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_RUN = 2'd2} state_t;

    localparam logic [SAMPLE_W-1:0] MAG_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [9:0]  MID_X  = 10'(PITCH_MID_XINGS);
    localparam logic [9:0]  HIGH_X = 10'(PITCH_HIGH_XINGS);
    localparam logic [11:0] MIN_S  = 12'(MIN_SAMPLES);

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] peak_q, peak_d, peak_acc;
    logic [9:0]          xings_q, xings_d, xings_acc;
    logic [11:0]         samples_q, samples_d, samples_acc;
    logic                prev_sign_q, prev_sign_d, prev_acc;
    logic                read_ack_q, read_ack_d;
    logic [1:0]          pitch_q, pitch_d;
    logic                volumn_q, volumn_d;
    logic                valid_q, valid_d;
    logic [11:0]         fsamp_q, fsamp_d;
    logic                overrun_q, overrun_d;

    logic                accept, close, clr_acc, sign;
    logic [SAMPLE_W-1:0] neg, mag;

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_ARM;
                S_ARM:   if (frame_tick) state_d = S_RUN;
                S_RUN:   state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sign    = left[SAMPLE_W-1];
        accept  = (state_q == S_RUN) && enable && read_ready;
        close   = (state_q == S_RUN) && enable && frame_tick;
        clr_acc = (state_q != S_RUN) || !enable || frame_tick;
        neg     = -left;
        // Only the most negative code negates to itself; clamp it to the largest positive.
        mag     = sign ? (neg[SAMPLE_W-1] ? MAG_MAX : neg) : left;

        peak_acc    = (accept && (mag > peak_q)) ? mag : peak_q;
        xings_acc   = xings_q + 10'((accept && prev_sign_q && !sign && (xings_q != 10'h3FF)) ? 1 : 0);
        samples_acc = samples_q + 12'((accept && (samples_q != 12'hFFF)) ? 1 : 0);
        prev_acc    = accept ? sign : prev_sign_q;

        peak_d      = clr_acc ? '0 : peak_acc;
        xings_d     = clr_acc ? '0 : xings_acc;
        samples_d   = clr_acc ? '0 : samples_acc;
        prev_sign_d = (!enable || (state_q == S_IDLE)) ? 1'b0 : prev_acc;
        read_ack_d  = accept;

        pitch_d   = pitch_q;
        volumn_d  = volumn_q;
        fsamp_d   = fsamp_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (!enable) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else if (close) begin
            fsamp_d = samples_acc;
            if (samples_acc < MIN_S) begin
                pitch_d  = 2'b00;
                volumn_d = 1'b0;
            end else begin
                pitch_d  = (xings_acc < MID_X) ? 2'b00 : ((xings_acc < HIGH_X) ? 2'b01 : 2'b11);
                volumn_d = (peak_acc >= VOL_THRESH);
            end
            valid_d = 1'b1;
            if (valid_q && !result_ack) overrun_d = 1'b1;
        end else if (result_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            peak_q      <= '0;
            xings_q     <= '0;
            samples_q   <= '0;
            prev_sign_q <= 1'b0;
            read_ack_q  <= 1'b0;
            pitch_q     <= 2'b00;
            volumn_q    <= 1'b0;
            valid_q     <= 1'b0;
            fsamp_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            peak_q      <= peak_d;
            xings_q     <= xings_d;
            samples_q   <= samples_d;
            prev_sign_q <= prev_sign_d;
            read_ack_q  <= read_ack_d;
            pitch_q     <= pitch_d;
            volumn_q    <= volumn_d;
            valid_q     <= valid_d;
            fsamp_q     <= fsamp_d;
            overrun_q   <= overrun_d;
        end
    end

    assign read_ack      = read_ack_q;
    assign pitch         = pitch_q;
    assign volumn        = volumn_q;
    assign result_valid  = valid_q;
    assign frame_samples = fsamp_q;
    assign overrun       = overrun_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_analyser_frame_controller.sv
// Bench for analyser_frame_controller: scenario tasks plus randomized traffic, checked
// against a frame-level model that analyses each buffered frame when it closes.
module tb_analyser_frame_controller;
    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        read_ready;
    logic [23:0] left;
    logic        frame_tick;
    logic        result_ack;
    logic        read_ack;
    logic [1:0]  pitch;
    logic        volumn;
    logic        result_valid;
    logic [11:0] frame_samples;
    logic        overrun;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    analyser_frame_controller dut (
        .clk(clk), .resetn(resetn), .enable(enable), .read_ready(read_ready), .left(left),
        .frame_tick(frame_tick), .read_ack(read_ack), .result_ack(result_ack), .pitch(pitch),
        .volumn(volumn), .result_valid(result_valid), .frame_samples(frame_samples),
        .overrun(overrun), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Model state: samples of the open frame, sign carried in from earlier frames,
    // pending result queue (0 or 1 entries), last loaded result and sticky overrun.
    logic [23:0] frame_q[$];
    logic [14:0] exp_q[$];
    logic [14:0] m_last;
    logic        m_prev, m_ovr, m_run, exp_ack;

    wire [16:0] obs = {result_valid, overrun, pitch, volumn, frame_samples};

    function automatic logic [16:0] exp_vec();
        return {exp_q.size() != 0, m_ovr, m_last};
    endfunction

    function automatic void close_frame(input logic ak);
        logic [23:0] peak, m;
        int x, n;
        logic [1:0] p;
        logic v;
        peak = 0;
        x = 0;
        foreach (frame_q[i]) begin
            m = frame_q[i][23] ? ((frame_q[i] == 24'h800000) ? 24'h7FFFFF : (~frame_q[i] + 24'd1)) : frame_q[i];
            if (m > peak) peak = m;
            if (m_prev && !frame_q[i][23]) x++;
            m_prev = frame_q[i][23];
        end
        if (x > 1023) x = 1023;
        n = (frame_q.size() > 4095) ? 4095 : frame_q.size();
        if (n < 16) begin
            p = 2'b00;
            v = 1'b0;
        end else begin
            p = (x < 5) ? 2'b00 : ((x < 10) ? 2'b01 : 2'b11);
            v = (peak >= 24'h3FFFFF);
        end
        m_last = {p, v, 12'(n)};
        if (exp_q.size() != 0 && !ak) m_ovr = 1'b1;
        exp_q.delete();
        exp_q.push_back(m_last);
        frame_q.delete();
    endfunction

    task automatic cycle(input logic rr, input logic [23:0] s, input logic tk, input logic ak);
        read_ready = rr;
        left       = s;
        frame_tick = tk;
        result_ack = ak;
        @(posedge clk);
        exp_ack = m_run && rr && enable;
        if (!enable) begin
            m_run = 1'b0;
            m_prev = 1'b0;
            m_ovr = 1'b0;
            frame_q.delete();
            exp_q.delete();
        end else begin
            if (m_run && rr) frame_q.push_back(s);
            if (m_run && tk) close_frame(ak);
            else if (ak && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        #1;
        read_ready = 1'b0;
        frame_tick = 1'b0;
        result_ack = 1'b0;
    endtask

    task automatic feed_square(input int n, input int period, input logic [23:0] amp);
        for (int i = 0; i < n; i++)
            cycle(1'b1, (((i / (period / 2)) % 2) == 0) ? -amp : amp, 1'b0, 1'b0);
    endtask

    task automatic feed_const(input int n, input logic [23:0] s);
        for (int i = 0; i < n; i++) cycle(1'b1, s, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        resetn = 1'b0; enable = 1'b0; read_ready = 1'b0; left = '0;
        frame_tick = 1'b0; result_ack = 1'b0;
        frame_q.delete(); exp_q.delete();
        m_last = '0; m_prev = 1'b0; m_ovr = 1'b0; m_run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 17'd0 || read_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%b need 0/0", obs, read_ack);
        end
        @(negedge clk);
        resetn = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 24'h400000, 1'b0, 1'b0);
            checks++;
            if (read_ack !== 1'b0 || obs !== exp_vec()) begin
                errors++;
                $display("FAIL pre_arm_read got ack=%b obs=%h need ack=0 obs=%h", read_ack, obs, exp_vec());
            end
        end
        cycle(1'b1, 24'h400000, 1'b1, 1'b0);
        m_run = 1'b1;
        checks++;
        if (obs !== exp_vec() || read_ack !== 1'b0) begin
            errors++;
            $display("FAIL first_tick got %h ack=%b need %h ack=0", obs, read_ack, exp_vec());
        end
        cycle(1'b0, 24'h0, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_vec() || obs !== {1'b1, 1'b0, 2'b00, 1'b0, 12'd0}) begin
            errors++;
            $display("FAIL second_tick got %h need %h", obs, exp_vec());
        end
    endtask

    task automatic test_pitch;
        int periods[3] = '{200, 160, 80};
        logic [1:0] classes[3] = '{2'b00, 2'b01, 2'b11};
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 24'h0, 1'b1, 1'b1);
            feed_square(800, periods[k], 24'h100000);
            checks++;
            if (read_ack !== exp_ack) begin
                errors++;
                $display("FAIL pitch_read_ack got %b need %b", read_ack, exp_ack);
            end
            cycle(1'b0, 24'h0, 1'b1, 1'b1);
            checks++;
            if (obs !== exp_vec() || pitch !== classes[k] || volumn !== 1'b0) begin
                errors++;
                $display("FAIL pitch_period_%0d got %h pitch=%b need %h pitch=%b", periods[k], obs, pitch, exp_vec(), classes[k]);
            end
        end
    endtask

    task automatic test_volume;
        cycle(1'b0, 24'h0, 1'b1, 1'b1);
        cycle(1'b1, 24'h800000, 1'b0, 1'b0);
        feed_const(20, 24'h0);
        cycle(1'b0, 24'h0, 1'b1, 1'b1);
        checks++;
        if (obs !== exp_vec() || volumn !== 1'b1) begin
            errors++;
            $display("FAIL volume_saturate got %h need %h", obs, exp_vec());
        end
        cycle(1'b1, 24'h3FFFFE, 1'b0, 1'b0);
        feed_const(20, 24'h0);
        cycle(1'b0, 24'h0, 1'b1, 1'b1);
        checks++;
        if (obs !== exp_vec() || volumn !== 1'b0) begin
            errors++;
            $display("FAIL volume_below got %h need %h", obs, exp_vec());
        end
    endtask

    task automatic test_boundary;
        cycle(1'b0, 24'h0, 1'b1, 1'b1);
        feed_const(20, 24'h001000);
        cycle(1'b1, 24'h400000, 1'b1, 1'b1);
        checks++;
        if (obs !== exp_vec() || volumn !== 1'b1 || frame_samples !== 12'd21) begin
            errors++;
            $display("FAIL boundary_sample got %h need %h", obs, exp_vec());
        end
        checks++;
        if (read_ack !== 1'b1) begin
            errors++;
            $display("FAIL boundary_read_ack got %b need 1", read_ack);
        end
        cycle(1'b0, 24'h0, 1'b1, 1'b1);
        checks++;
        if (obs !== exp_vec() || frame_samples !== 12'd0) begin
            errors++;
            $display("FAIL boundary_next_empty got %h need %h", obs, exp_vec());
        end
    endtask

    task automatic test_handshake;
        feed_const(20, 24'h000100);
        cycle(1'b0, 24'h0, 1'b1, 1'b1);
        checks++;
        if (obs !== exp_vec() || result_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ack_with_tick got %h need %h", obs, exp_vec());
        end
        cycle(1'b0, 24'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_vec() || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_alone got %h need %h", obs, exp_vec());
        end
        cycle(1'b0, 24'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL ack_while_idle got %h need %h", obs, exp_vec());
        end
        feed_const(20, 24'h000200);
        cycle(1'b0, 24'h0, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_vec() || overrun !== 1'b0) begin
            errors++;
            $display("FAIL first_unacked got %h need %h", obs, exp_vec());
        end
        for (int i = 0; i < 17; i++) cycle(1'b1, 24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 1'b0);
        cycle(1'b0, 24'h0, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_vec() || overrun !== 1'b1 || frame_samples !== 12'd17) begin
            errors++;
            $display("FAIL overrun got %h need %h", obs, exp_vec());
        end
    endtask

    task automatic test_short_disable;
        cycle(1'b0, 24'h0, 1'b1, 1'b1);
        feed_square(10, 2, 24'h7FFFFF);
        cycle(1'b0, 24'h0, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_vec() || pitch !== 2'b00 || volumn !== 1'b0 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL short_frame got %h need %h", obs, exp_vec());
        end
        feed_const(5, 24'h7FFFFF);
        enable = 1'b0;
        cycle(1'b0, 24'h0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_vec() || result_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL disable got %h need %h", obs, exp_vec());
        end
        cycle(1'b1, 24'h123456, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_vec() || read_ack !== 1'b0) begin
            errors++;
            $display("FAIL idle_tick got %h ack=%b need %h ack=0", obs, read_ack, exp_vec());
        end
        enable = 1'b1;
        cycle(1'b0, 24'h0, 1'b0, 1'b0);
        cycle(1'b0, 24'h0, 1'b0, 1'b0);
        cycle(1'b0, 24'h0, 1'b1, 1'b0);
        m_run = 1'b1;
        checks++;
        if (obs !== exp_vec() || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL rearm_tick got %h need %h", obs, exp_vec());
        end
        feed_const(3, 24'h000010);
        cycle(1'b0, 24'h0, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_vec() || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL rearm_result got %h need %h", obs, exp_vec());
        end
    endtask

    task automatic test_random;
        logic loud;
        logic rr, tk, ak;
        logic [23:0] s;
        int r;
        loud = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rr = ($urandom_range(0, 9) < 7);
            tk = ($urandom_range(0, 39) == 0);
            ak = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 15);
            if (r == 0 && loud) s = 24'($urandom);
            else if (r == 1 && loud) s = 24'h800000;
            else s = 24'($signed(16'($urandom)));
            cycle(rr, s, tk, ak);
            if (tk) loud = $urandom_range(0, 1);
            checks++;
            if (obs !== exp_vec() || read_ack !== exp_ack) begin
                errors++;
                $display("FAIL random_cycle_%0d got %h ack=%b need %h ack=%b", i, obs, read_ack, exp_vec(), exp_ack);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pitch();
        test_volume();
        test_boundary();
        test_handshake();
        test_short_disable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
